// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT_R = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } lsu_state_e;

    // RV32I width/sign codes; stores use only the B/H/W encodings.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables/replication with legality checks,
// and load byte/half extraction with sign or zero extension.
module lsu_align import lsu_pkg::*; (
    input  logic        st_write,
    input  logic [2:0]  st_func3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_o,
    output logic        st_illegal,
    output logic        st_misaligned,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_illegal    = 1'b0;
        st_misaligned = 1'b0;
        st_be         = 4'b1111;
        st_wdata_o    = '0;

        if (st_write) begin
            st_illegal = !(st_func3 inside {F3_B, F3_H, F3_W});
        end else begin
            st_illegal = !(st_func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end

        // func3[1:0] encodes the access width for every legal code.
        case (st_func3[1:0])
            2'b01:   st_misaligned = st_addr_lo[0];
            2'b10:   st_misaligned = (st_addr_lo != 2'b00);
            default: st_misaligned = 1'b0;
        endcase

        // Reads always fetch the full word; only stores need lane enables.
        if (st_write) begin
            case (st_func3[1:0])
                2'b00: begin
                    st_be      = 4'b0001 << st_addr_lo;
                    st_wdata_o = {4{st_wdata[7:0]}};
                end
                2'b01: begin
                    st_be      = 4'b0011 << st_addr_lo;
                    st_wdata_o = {2{st_wdata[15:0]}};
                end
                default: begin
                    st_be      = 4'b1111;
                    st_wdata_o = st_wdata;
                end
            endcase
        end
    end

    always_comb begin
        ld_shift = ld_rdata >> {ld_addr_lo, 3'b000};
        case (ld_func3)
            F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
            F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: stalls the core while one access runs on a
// gnt/rvalid memory port, with alignment/legality traps and a bus timeout.
//
// Handshake: mem_req is held with stable mem_we/addr/be/wdata until a cycle with
// mem_gnt=1 (transfer accepted on that edge); load data is taken on the first
// cycle with mem_rvalid=1 at or after the grant. gnt/rvalid outside REQ/WAIT_R
// are ignored.
module lsu_sequencer import lsu_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output lsu_state_e        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        func3_q;
    logic [31:0]       load_data_q;
    logic              err_bus_q, err_bus_d;
    logic              latch_en;
    logic              capture;

    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic              al_illegal;
    logic              al_misaligned;
    logic [31:0]       al_ld_data;

    lsu_align u_align (
        .st_write      (req_write),
        .st_func3      (req_func3),
        .st_addr_lo    (req_addr[1:0]),
        .st_wdata      (req_wdata),
        .st_be         (al_be),
        .st_wdata_o    (al_wdata),
        .st_illegal    (al_illegal),
        .st_misaligned (al_misaligned),
        .ld_func3      (func3_q),
        .ld_addr_lo    (addr_q[1:0]),
        .ld_rdata      (mem_rdata),
        .ld_data       (al_ld_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_bus_d = err_bus_q;
        latch_en  = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    if (al_illegal || al_misaligned) begin
                        state_d   = ERR;
                        err_bus_d = 1'b0;
                    end else begin
                        state_d  = REQ;
                        latch_en = 1'b1;
                        cnt_d    = CNT_W'(1);
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completing handshake takes priority over an expiring timeout.
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        state_d = DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (cnt_q == TMO) begin
                    state_d   = ERR;
                    err_bus_d = 1'b1;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else if (cnt_q == TMO) begin
                    state_d   = ERR;
                    err_bus_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            ERR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_bus_q   <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            func3_q     <= '0;
            load_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_bus_q <= err_bus_d;
            if (latch_en) begin
                addr_q  <= req_addr;
                we_q    <= req_write;
                be_q    <= al_be;
                wdata_q <= al_wdata;
                func3_q <= req_func3;
            end
            if (capture) begin
                load_data_q <= al_ld_data;
            end
        end
    end

    // rst_n gates stall so the core is released the moment reset asserts.
    assign stall        = rst_n & req_valid & (state_q inside {IDLE, REQ, WAIT_R});
    assign load_valid   = (state_q == DONE) & ~we_q;
    assign misalign_err = (state_q == ERR) & ~err_bus_q;
    assign bus_err      = (state_q == ERR) & err_bus_q;
    assign load_data    = load_data_q;
    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_req & we_q;
    assign mem_addr     = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be       = mem_req ? be_q : 4'b0000;
    assign mem_wdata    = mem_req ? wdata_q : 32'h0;
    assign dbg_state    = state_q;

    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q inside {REQ, WAIT_R}) |-> req_valid);

endmodule
